// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Op codes, FSM state enum and default operand width.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Ports: is_div mode, acc {hi,lo} state, opnd multiplicand/divisor,
// acc_next next state (quotient slot left 0), q_bit new quotient bit.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH-1:0] upper;
   logic [WIDTH-1:0] lower;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;

   always_comb begin
      upper  = acc[2*WIDTH-1:WIDTH];
      lower  = acc[WIDTH-1:0];
      sum    = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : '0);
      // Trial subtraction needs one extra bit for the shifted remainder.
      rem_sh = {upper, lower[WIDTH-1]};
      q_bit  = rem_sh >= {1'b0, opnd};
      // When q_bit is set the true difference fits in WIDTH bits.
      diff   = rem_sh[WIDTH-1:0] - opnd;
      if (is_div) begin
         acc_next = {(q_bit ? diff : rem_sh[WIDTH-1:0]),
                     lower[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {sum, lower[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
// Ports: clk_i, rst_i (sync, high), start_i/op_i/src1_i/src2_i request,
// flush_i abort, busy_o stall, done_o result pulse, hi_o/lo_o results.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e             state_q, state_d;
   op_e                op_q, op_in;
   logic               s1_q, s2_q;
   logic [5:0]         cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_nx;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               q_bit;
   logic               is_div, dz;
   logic               in_div, in_sgn, in_s1, in_s2;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem, quo;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .is_div   (is_div),
      .acc      (acc_q),
      .opnd     (opnd_q),
      .acc_next (acc_nx),
      .q_bit    (q_bit)
   );

   // Request decode: signed ops work on magnitudes plus sign flags.
   always_comb begin
      op_in  = op_e'(op_i);
      in_div = (op_in == OP_DIVU) || (op_in == OP_DIV);
      in_sgn = (op_in == OP_MULT) || (op_in == OP_DIV);
      in_s1  = in_sgn & src1_i[WIDTH-1];
      in_s2  = in_sgn & src2_i[WIDTH-1];
      mag1   = in_s1 ? -src1_i : src1_i;
      mag2   = in_s2 ? -src2_i : src2_i;
   end

   assign is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);
   assign dz     = (opnd_q == '0);

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b1;
      done_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i && !flush_i) state_d = S_CALC;
         end
         S_CALC: begin
            if (flush_i)                      state_d = S_IDLE;
            else if (cnt_q == 6'(WIDTH - 1))  state_d = S_FIX;
         end
         S_FIX: begin
            state_d = flush_i ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Sign fix-up; a zero divisor reports the dividend and all-ones.
   always_comb begin
      rem    = acc_q[2*WIDTH-1:WIDTH];
      quo    = acc_q[WIDTH-1:0];
      prod   = acc_q;
      fix_hi = rem;
      fix_lo = quo;
      unique case (1'b1)
         (!is_div): begin
            prod   = (s1_q ^ s2_q) ? -acc_q : acc_q;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
         end
         (is_div && dz): begin
            fix_hi = s1_q ? -rem : rem;
            fix_lo = '1;
         end
         (is_div && !dz): begin
            fix_hi = s1_q ? -rem : rem;
            fix_lo = (s1_q ^ s2_q) ? -quo : quo;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q   <= OP_MULTU;
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         if (state_q == S_IDLE && state_d == S_CALC) begin
            op_q   <= op_in;
            s1_q   <= in_s1;
            s2_q   <= in_s2;
            cnt_q  <= '0;
            // Multiply shifts the multiplier out of LO; divide
            // shifts the dividend out of LO into the remainder.
            acc_q  <= {{WIDTH{1'b0}}, in_div ? mag1 : mag2};
            opnd_q <= in_div ? mag2 : mag1;
         end
         if (state_q == S_CALC) begin
            acc_q <= {acc_nx[2*WIDTH-1:1], is_div ? q_bit : acc_nx[0]};
            cnt_q <= cnt_q + 6'd1;
         end
         if (state_q == S_FIX && !flush_i) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl.
// Scoreboard of expected HI/LO and done cycle, popped on done_o.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src1, src2;
   logic        flush;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      logic [63:0] res;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [63:0] last_res = '0;

   muldiv_ctrl dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .op_i    (op),
      .src1_i  (src1),
      .src2_i  (src2),
      .flush_i (flush),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] p;
      logic signed [31:0] sa, sb2, q, r;
      sa  = a;
      sb2 = b;
      case (o)
         2'b00: return {32'h0, a} * {32'h0, b};
         2'b01: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return p;
         end
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            q = sa / sb2;
            r = sa % sb2;
            return {r, q};
         end
      endcase
   endfunction

   // done_o must land exactly on the cycle recorded at issue.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("hi", 64'(hi), 64'(e.res[63:32]));
            check("lo", 64'(lo), 64'(e.res[31:0]));
            check("latency", 64'(cyc), 64'(e.due));
            check("busy_at_done", 64'(busy), 64'd1);
            last_res = e.res;
         end
      end
   end

   // Called at a negedge; start is sampled at the next posedge (edge N).
   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input bit track, output int n);
      start = 1'b1;
      op    = o;
      src1  = a;
      src2  = b;
      @(negedge clk);
      n     = cyc;
      start = 1'b0;
      src1  = $urandom;
      src2  = $urandom;
      // DONE is cycle N+34, i.e. the cycle after edge N+33.
      if (track) sb.push_back('{exp, n + 33});
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && busy; i++) @(negedge clk);
      if (busy) check("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
      int n;
      issue(o, a, b, exp, 1'b1, n);
      wait_idle();
   endtask

   task automatic to_cycle(input int c);
      for (int i = 0; i < 100 && cyc < c; i++) @(negedge clk);
   endtask

   initial begin
      int          n;
      logic [1:0]  o;
      logic [31:0] a, b;
      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      src1  = '0;
      src2  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      check("idle_after_done", 64'(busy), 64'd0);
      run(2'b01, -32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run(2'b11, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run(2'b10, 32'd10, 32'd0, 64'h0000_000A_FFFF_FFFF);
      run(2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
      run(2'b11, -32'sd5, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);

      // Start during CALC is ignored; back-to-back start is accepted.
      issue(2'b10, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 1'b1, n);
      to_cycle(n + 4);
      start = 1'b1;
      op    = 2'b00;
      src1  = 32'd5;
      src2  = 32'd5;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      run(2'b01, 32'd7, -32'sd6, 64'hFFFF_FFFF_FFFF_FFD6);

      // Flush mid-CALC.
      issue(2'b00, 32'd9, 32'd9, '0, 1'b0, n);
      to_cycle(n + 9);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_calc_busy", 64'(busy), 64'd0);
      check("flush_calc_hi", 64'(hi), 64'(last_res[63:32]));
      check("flush_calc_lo", 64'(lo), 64'(last_res[31:0]));
      repeat (40) @(negedge clk);

      // Flush with start in IDLE drops the start.
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_idle", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);

      // Flush in FIX discards the result.
      issue(2'b10, 32'd50, 32'd5, '0, 1'b0, n);
      to_cycle(n + 32);
      check("fix_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_fix_busy", 64'(busy), 64'd0);
      check("flush_fix_hi", 64'(hi), 64'(last_res[63:32]));
      check("flush_fix_lo", 64'(lo), 64'(last_res[31:0]));
      repeat (40) @(negedge clk);

      // Flush in DONE has no effect.
      issue(2'b00, 32'd3, 32'd4, 64'd12, 1'b1, n);
      to_cycle(n + 33);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_done_busy", 64'(busy), 64'd0);
      check("flush_done_lo", 64'(lo), 64'd12);

      for (int i = 0; i < 10; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i % 4 == 3) b = '0;
         run(o, a, b, model(o, a, b));
      end

      // Reset mid-CALC.
      issue(2'b00, 32'd123, 32'd456, '0, 1'b0, n);
      to_cycle(n + 19);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_hi", 64'(hi), 64'd0);
      check("rst_mid_lo", 64'(lo), 64'd0);
      run(2'b00, 32'd6, 32'd7, 64'd42);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
